// File: rtl/sar_controller.sv
// sar_controller: successive-approximation sequencer driving the bit-select decoder and DAC code
module sar_controller #(
  parameter int width = 3,
  parameter int sample_cycles = 4,
  parameter int settle_cycles = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cmp,
  output logic                    sample,
  output logic                    sel_en,
  output logic [width-1:0]        sel,
  output logic [(1<<width)-1:0]   dac_code,
  output logic [(1<<width)-1:0]   result,
  output logic                    busy,
  output logic                    done
);
  localparam int N = 1 << width;
  localparam int CMAX = sample_cycles > settle_cycles ? sample_cycles : settle_cycles;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [width-1:0] sel_q, sel_d, sel_m1;
  logic [N-1:0] dac_q, dac_d, result_q, result_d;
  logic sample_q, sample_d, sel_en_q, sel_en_d, busy_q, busy_d, done_q, done_d;
  assign sel_m1 = sel_q - 1'b1;
  // next-state and next-output computation; outputs are the values for the coming state
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    dac_d = dac_q;
    result_d = result_q;
    sample_d = 1'b0;
    sel_en_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        dac_d = '0;
        cnt_d = CW'(sample_cycles - 1);
        if (start) begin
          state_d = SAMPLE;
          sample_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      SAMPLE: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = TRIAL;
          sel_en_d = 1'b1;
          sel_d = width'(N - 1);
          dac_d[N-1] = 1'b1;
          cnt_d = CW'(settle_cycles - 1);
        end else begin
          sample_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      TRIAL: begin
        busy_d = 1'b1;
        sel_en_d = 1'b1;
        if (cnt_q == '0) begin
          dac_d[sel_q] = cmp;
          if (sel_q != '0) begin
            sel_d = sel_m1;
            dac_d[sel_m1] = 1'b1;
            cnt_d = CW'(settle_cycles - 1);
          end else begin
            state_d = DONE;
            busy_d = 1'b0;
            sel_en_d = 1'b0;
            done_d = 1'b1;
            sel_d = '0;
            result_d = dac_d;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dac_d = '0;
      end
    endcase
  end
  // state and registered outputs; reset aborts any conversion and clears the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      dac_q <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      sel_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      dac_q <= dac_d;
      result_q <= result_d;
      sample_q <= sample_d;
      sel_en_q <= sel_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign sample = sample_q;
  assign sel_en = sel_en_q;
  assign sel = sel_q;
  assign dac_code = dac_q;
  assign result = result_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: directed and randomized conversions checked against a binary-search model
module tb_sar_controller;
  localparam int S = 4;
  localparam int N = 8;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, cmp = 1'b0;
  logic a_sample, a_sel_en, a_busy, a_done, b_sample, b_sel_en, b_busy, b_done;
  logic [2:0] a_sel, b_sel;
  logic [7:0] a_dac, a_result, b_dac, b_result;
  bit use_b = 1'b0;
  logic o_sample, o_sel_en, o_busy, o_done;
  logic [2:0] o_sel;
  logic [7:0] o_dac, o_result;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] tgt;
  always #5 clk = ~clk;
  sar_controller #(.width(3), .sample_cycles(4), .settle_cycles(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .cmp(cmp), .sample(a_sample), .sel_en(a_sel_en),
    .sel(a_sel), .dac_code(a_dac), .result(a_result), .busy(a_busy), .done(a_done));
  sar_controller #(.width(3), .sample_cycles(4), .settle_cycles(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .cmp(cmp), .sample(b_sample), .sel_en(b_sel_en),
    .sel(b_sel), .dac_code(b_dac), .result(b_result), .busy(b_busy), .done(b_done));
  assign o_sample = use_b ? b_sample : a_sample;
  assign o_sel_en = use_b ? b_sel_en : a_sel_en;
  assign o_busy = use_b ? b_busy : a_busy;
  assign o_done = use_b ? b_done : a_done;
  assign o_sel = use_b ? b_sel : a_sel;
  assign o_dac = use_b ? b_dac : a_dac;
  assign o_result = use_b ? b_result : a_result;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // one conversion: cmp follows the model's trial code; wrong=1 inverts cmp on all but the last cycle of a trial
  task automatic run_conv(input logic [7:0] t_val, input bit wrong, input bit pulse, input bit hold, input bit pre);
    int t, d, i, ph;
    logic [7:0] code, trial;
    t = use_b ? 3 : 1;
    d = S + N * t + 1;
    code = 8'd0;
    trial = 8'd0;
    if (!pre) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    for (int k = 1; k <= d; k++) begin
      chk("busy", o_busy, 32'(k < d));
      chk("done", o_done, 32'(k == d));
      chk("sample", o_sample, 32'(k <= S));
      chk("sel_en", o_sel_en, 32'(k > S && k < d));
      if (k > S && k < d) begin
        i = N - 1 - (k - S - 1) / t;
        ph = (k - S - 1) % t;
        if (ph == 0) trial = code | (8'd1 << i);
        chk("sel", o_sel, i);
        chk("dac", o_dac, trial);
        cmp = (t_val >= trial) ^ (wrong && ph < t - 1);
        if (ph == t - 1 && t_val >= trial) code = trial;
      end
      if (k == d) begin
        chk("result", o_result, t_val);
        chk("dac_final", o_dac, t_val);
        chk("sel_done", o_sel, 0);
      end
      start = hold || (pulse && (k == 2 || k == 7));
      @(posedge clk); #1;
    end
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("idle_sample", o_sample, 0);
    chk("result_hold", o_result, t_val);
    if (hold) begin
      @(posedge clk); #1;
      chk("restart_sample", o_sample, 1);
      chk("restart_busy", o_busy, 1);
    end
  endtask
  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_sample", o_sample, 0);
    chk("rst_sel_en", o_sel_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_dac", o_dac, 0);
    chk("rst_result", o_result, 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_sample", o_sample, 0);
    end
    run_conv(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_conv(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_conv(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_conv(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) run_conv(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_conv(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, 1'b0);
    run_conv(8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmp = 1'($urandom_range(0, 1));
    repeat (7) @(posedge clk);
    #1;
    chk("abort_sel", o_sel, 4);
    chk("abort_busy_pre", o_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_sel_en", o_sel_en, 0);
    chk("abort_result", o_result, 0);
    chk("abort_dac", o_dac, 0);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", o_done, 0);
      chk("abort_idle", o_busy, 0);
    end
    run_conv(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    use_b = 1'b1;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_conv(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      tgt = 8'($urandom_range(0, 255));
      run_conv(tgt, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sar_controller.md
# sar_controller

Successive-approximation sequencer for the SAR ADC data path. On a start request it runs a sample phase, then walks the bit index from MSB to LSB through the one-hot bit-select decoder. It builds the trial DAC code, resolves each bit from the comparator, and presents the final code with a one-cycle done strobe. It sits between the pixel readout control and the data path: it drives the decoder's `enable`/`in` inputs and the DAC code register.

## Interface
- `width`, 3: bit-index width; conversion resolution is N = 2**width bits (default 8).
- `sample_cycles`, 4: cycles the sample/hold switch is closed; must be ≥ 1.
- `settle_cycles`, 1: cycles per bit trial before the comparator is sampled; must be ≥ 1.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `cmp`  in  1  comparator output: 1 means input ≥ trial DAC level, so the bit is kept.
- `sample`  out  1  sample/hold switch control.
- `sel_en`  out  1  decoder enable.
- `sel`  out  width  bit index to decoder.
- `dac_code`  out  N  current trial code to the DAC.
- `result`  out  N  last completed conversion; held until the next DONE.
- `busy`  out  1  high in SAMPLE and TRIAL.
- `done`  out  1  one-cycle completion strobe.

## Operation
- All outputs are registered.
- Reset (asynchronous): state = IDLE; `sample`, `sel_en`, `busy`, `done` = 0; `sel`, `dac_code`, `result` = 0.
- States: IDLE, SAMPLE, TRIAL, DONE.
- IDLE:
  - If `start`=1 at an edge, go to SAMPLE.
  - `dac_code` is cleared to 0.
  - The cycle counter is loaded with `sample_cycles`-1.
- SAMPLE:
  - `sample`=1 and `busy`=1; the counter decrements each cycle.
  - At the edge where the counter is 0, go to TRIAL with `sel` = N-1 and `dac_code[N-1]` = 1.
  - The counter is loaded with `settle_cycles`-1.
- TRIAL (bit i = `sel`):
  - `sel_en`=1 and `busy`=1. `dac_code` holds the resolved upper bits, bit i = 1, and lower bits = 0.
  - At the edge where the counter is 0:
    - `dac_code[i]` takes `cmp`.
    - If i > 0: `sel` becomes i-1, `dac_code[i-1]` becomes 1, and the counter reloads.
    - If i = 0: go to DONE, and `result` takes the final code (with bit 0 = `cmp`).
  - `cmp` is ignored on all earlier cycles of a trial.
- DONE:
  - Lasts exactly one cycle: `done`=1, `busy`=0, `sel_en`=0.
  - `dac_code` keeps the final value; `sel` = 0.
  - Returns to IDLE unconditionally.
- `start` in SAMPLE, TRIAL or DONE is ignored and is not queued. `start` held high re-triggers in the first IDLE cycle after DONE.
- Reset mid-conversion aborts immediately: no `done` strobe, and `result` is cleared to 0.
- The `sel` index decrements from N-1 to 0 with no wrap. `sel` does not change outside TRIAL except when loaded on the SAMPLE→TRIAL edge and cleared on entering DONE.

## Timing
- Number cycles from 1, where cycle 1 is the cycle after the edge that samples `start`=1.
  - SAMPLE occupies cycles 1..S, with S = `sample_cycles`.
  - Bit i occupies a window of T = `settle_cycles` cycles, starting at cycle S + (N-1-i)·T + 1.
  - DONE is cycle S + N·T + 1. This is cycle 13 at defaults.
  - `result` is valid from the DONE cycle onward.
- Minimum start-to-start period: S + N·T + 2 cycles (DONE plus one IDLE cycle). This is 14 at defaults.
- `cmp` must be stable at the last edge of each trial window. It has one full clock (T=1) from the `dac_code`/`sel` update to the sample point.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle → all outputs 0 immediately; still IDLE after release.
- **Mid-scale conversion:** bench model `cmp` = (target ≥ `dac_code`), target 8'hA5 at defaults, `start` pulse →
  - `sample` high for 4 cycles;
  - `sel` steps 7,6,…,0 with `sel_en`=1;
  - `dac_code` trials 80,C0,A0,B0,A8,A4,A6,A5;
  - `done` in cycle 13 with `result`=8'hA5.
- **Extremes:** target 8'hFF → `result`=FF. Target 8'h00 → `result`=00; every trial bit is cleared the edge after it is set.
- **Start handling:** pulse `start` during SAMPLE and TRIAL → no effect, single `done`. `start` held high → second conversion's SAMPLE begins cycle 15, period 14.
- **Abort:** assert `reset` during TRIAL of bit 4 → `busy`/`sel_en`=0 and `result`=0 at once, no `done`. Next `start` with target 8'h3C → `result`=3C.
- **Settle timing:** `settle_cycles`=3, target 8'h5A, `cmp` forced wrong in the first two cycles of every trial → `result`=5A, `done` in cycle 29.
